// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard/stall controller for the 5-stage MIPS core.
// Detects load-use, mult/div-busy and data-memory-wait hazards and drives the
// PC/IF-ID enables, the bubble/flush controls and the pipeline freeze.
// It also owns the mult/div latency counter and the memory-wait watchdog.
// Optional macro HAZARD_PERF_CNT_EN adds the StallCount performance counter.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY  = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_MdStart,
  input  logic       ID_MdRead,
  input  logic [4:0] EX_write_reg,
  input  logic       EX_MemRead,
  input  logic       BranchTaken,
  input  logic       Jump,
  input  logic       MEM_MemAccess,
  input  logic       DMemReady,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       PipeFreeze,
  output logic       MdBusy,
  output logic       MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount
`endif
);

  localparam logic [7:0]  LP_MD_LAT  = 8'(MD_LATENCY);
  localparam logic [15:0] LP_TIMEOUT = 16'(MEM_TIMEOUT);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_md_cnt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_inc;
  logic        r_timeout;
  logic        w_in_wait;
  logic        w_freeze;
  logic        w_lu;
  logic        w_md;
  logic        w_md_busy;
  logic        w_md_load;

  assign w_freeze  = MEM_MemAccess & ~DMemReady;
  assign w_lu      = EX_MemRead & (EX_write_reg != 5'd0) &
                     ((ID_UseRs & (EX_write_reg == ID_rs)) |
                      (ID_UseRt & (EX_write_reg == ID_rt)));
  assign w_md_busy = (r_md_cnt != '0);
  assign w_md      = w_md_busy & (ID_MdStart | ID_MdRead);
  // A mult/div only starts the unit when it actually leaves ID.
  assign w_md_load = ID_MdStart & ~w_freeze & ~w_lu & ~w_md;

  assign MdBusy     = w_md_busy;
  assign MemTimeout = r_timeout;

  // Prioritised pipeline controls: reset, freeze, stall, redirect, run.
  always_comb begin
    PCWrite    = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PipeFreeze = 1'b0;
    if (reset) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (w_freeze) begin
      PipeFreeze = 1'b1;
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
    end else if (w_lu | w_md) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (BranchTaken | Jump) begin
      IFID_Flush = 1'b1;
    end
  end

  // Mult/div latency counter: load on issue, else count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_md_load) begin
      r_md_cnt <= LP_MD_LAT;
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - 8'd1;
    end
  end

  // Memory-wait FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-wait FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_freeze)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (~w_freeze) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Memory-wait FSM outputs.
  always_comb begin
    w_in_wait = (r_state == ST_WAIT);
  end

  assign w_wait_inc = (r_wait_cnt == '1) ? r_wait_cnt : (r_wait_cnt + 16'd1);

  // Saturating wait counter, cleared whenever the FSM is in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (!w_in_wait) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_inc;
    end
  end

  // Sticky watchdog flag, set on the edge the wait count reaches the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_in_wait && (w_wait_inc == LP_TIMEOUT)) begin
      r_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  assign StallCount = r_stall_cnt;

  // Count every cycle the PC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!PCWrite) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios then random stimulus,
// all checked against a behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 4;
  localparam int MEM_TO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_write_reg;
  logic       ID_UseRs, ID_UseRt, ID_MdStart, ID_MdRead;
  logic       EX_MemRead, BranchTaken, Jump, MEM_MemAccess, DMemReady;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, PipeFreeze;
  logic       MdBusy, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount;
`endif

  hazard_stall_ctrl #(
    .MD_LATENCY (MD_LAT),
    .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_UseRs     (ID_UseRs),
    .ID_UseRt     (ID_UseRt),
    .ID_MdStart   (ID_MdStart),
    .ID_MdRead    (ID_MdRead),
    .EX_write_reg (EX_write_reg),
    .EX_MemRead   (EX_MemRead),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .MEM_MemAccess(MEM_MemAccess),
    .DMemReady    (DMemReady),
    .PCWrite      (PCWrite),
    .IFID_Write   (IFID_Write),
    .IFID_Flush   (IFID_Flush),
    .IDEX_Flush   (IDEX_Flush),
    .PipeFreeze   (PipeFreeze),
    .MdBusy       (MdBusy),
    .MemTimeout   (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount   (StallCount)
`endif
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  int          m_md_rem    = 0;   // cycles the MDU is still busy
  bit          m_in_wait   = 0;   // inside a memory wait episode
  int          m_wait_cyc  = 0;   // wait cycles counted so far (saturating)
  bit          m_timeout   = 0;
  logic [31:0] m_stall     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = '0; ID_rt = '0; EX_write_reg = '0;
    ID_UseRs = 0; ID_UseRt = 0; ID_MdStart = 0; ID_MdRead = 0;
    EX_MemRead = 0; BranchTaken = 0; Jump = 0;
    MEM_MemAccess = 0; DMemReady = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic step(input string tag);
    bit frz, lu, md;
    bit e_pc, e_ifw, e_iff, e_idf, e_pf;
    @(negedge clk);
    frz = MEM_MemAccess && !DMemReady;
    lu  = EX_MemRead && (EX_write_reg != 0) &&
          ((ID_UseRs && EX_write_reg == ID_rs) || (ID_UseRt && EX_write_reg == ID_rt));
    md  = (m_md_rem > 0) && (ID_MdStart || ID_MdRead);
    if (reset)            begin e_pc=0; e_ifw=0; e_iff=1; e_idf=1; e_pf=0; end
    else if (frz)         begin e_pc=0; e_ifw=0; e_iff=0; e_idf=0; e_pf=1; end
    else if (lu || md)    begin e_pc=0; e_ifw=0; e_iff=0; e_idf=1; e_pf=0; end
    else if (BranchTaken || Jump) begin e_pc=1; e_ifw=1; e_iff=1; e_idf=0; e_pf=0; end
    else                  begin e_pc=1; e_ifw=1; e_iff=0; e_idf=0; e_pf=0; end

    chk({tag, ".PCWrite"},    PCWrite,    e_pc);
    chk({tag, ".IFID_Write"}, IFID_Write, e_ifw);
    chk({tag, ".IFID_Flush"}, IFID_Flush, e_iff);
    chk({tag, ".IDEX_Flush"}, IDEX_Flush, e_idf);
    chk({tag, ".PipeFreeze"}, PipeFreeze, e_pf);
    chk({tag, ".MdBusy"},     MdBusy,     (m_md_rem > 0 && !reset));
    chk({tag, ".MemTimeout"}, MemTimeout, (m_timeout && !reset));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".StallCount"}, StallCount, reset ? 32'd0 : m_stall);
`endif

    if (reset) begin
      m_md_rem = 0; m_in_wait = 0; m_wait_cyc = 0; m_timeout = 0; m_stall = '0;
    end else begin
      if (!e_pc) m_stall = m_stall + 32'd1;
      if (ID_MdStart && !frz && !lu && !md) m_md_rem = MD_LAT;
      else if (m_md_rem > 0)                m_md_rem = m_md_rem - 1;
      if (m_in_wait) begin
        if (m_wait_cyc < 65535) m_wait_cyc = m_wait_cyc + 1;
        if (m_wait_cyc == MEM_TO) m_timeout = 1;
      end else begin
        m_wait_cyc = 0;
      end
      m_in_wait = frz;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step("reset");
    reset = 0;
    step("idle");

    // Load-use: one stall cycle, then release once the load has moved on
    EX_MemRead = 1; EX_write_reg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1;
    step("lu_stall");
    EX_MemRead = 0;
    step("lu_release");
    idle();

    // rt path and unused-operand path
    EX_MemRead = 1; EX_write_reg = 5'd9; ID_rt = 5'd9; ID_UseRt = 1;
    step("lu_rt");
    ID_UseRt = 0;
    step("lu_rt_unused");
    idle();

    // $zero never stalls
    EX_MemRead = 1; EX_write_reg = 5'd0; ID_rs = 5'd0; ID_UseRs = 1;
    step("zero_reg");
    idle();

    // MDU: mult leaves ID, mfhi waits MD_LAT cycles
    ID_MdStart = 1;
    step("mult_issue");
    ID_MdStart = 0; ID_MdRead = 1;
    for (int i = 0; i < MD_LAT + 2; i++) step("mfhi_wait");
    idle();

    // Memory wait of 3 cycles, release on the 4th
    MEM_MemAccess = 1;
    for (int i = 0; i < 3; i++) step("mem_wait");
    DMemReady = 1;
    step("mem_release");
    idle();
    step("mem_after");

    // Watchdog: stays set after memory completes
    MEM_MemAccess = 1;
    for (int i = 0; i < MEM_TO + 3; i++) step("timeout_wait");
    DMemReady = 1;
    step("timeout_release");
    idle();
    for (int i = 0; i < 3; i++) step("timeout_sticky");
    reset = 1;
    step("timeout_reset");
    reset = 0;
    step("post_reset");

    // Branch with load-use: stall wins, no IF/ID flush
    EX_MemRead = 1; EX_write_reg = 5'd3; ID_rs = 5'd3; ID_UseRs = 1; BranchTaken = 1;
    step("br_vs_lu");
    EX_MemRead = 0;
    step("br_taken");
    BranchTaken = 0; Jump = 1;
    step("jump");
    idle();

    // Freeze during load-use: freeze first, lu re-evaluated on release
    EX_MemRead = 1; EX_write_reg = 5'd4; ID_rt = 5'd4; ID_UseRt = 1;
    MEM_MemAccess = 1;
    step("frz_lu");
    DMemReady = 1;
    step("frz_lu_release");
    idle();

    // Reset in the middle of an MDU operation and a memory wait
    ID_MdStart = 1;
    step("mdu_issue2");
    ID_MdStart = 0; MEM_MemAccess = 1;
    step("mdu_wait2");
    reset = 1;
    step("reset_mid");
    reset = 0; idle();
    ID_MdRead = 1;
    step("after_reset_mid");
    idle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 149) == 0);
      ID_rs         = 5'($urandom_range(0, 3));
      ID_rt         = 5'($urandom_range(0, 3));
      EX_write_reg  = 5'($urandom_range(0, 3));
      ID_UseRs      = $urandom_range(0, 1) == 1;
      ID_UseRt      = $urandom_range(0, 1) == 1;
      ID_MdStart    = $urandom_range(0, 5) == 0;
      ID_MdRead     = $urandom_range(0, 3) == 0;
      EX_MemRead    = $urandom_range(0, 2) == 0;
      BranchTaken   = $urandom_range(0, 4) == 0;
      Jump          = $urandom_range(0, 6) == 0;
      MEM_MemAccess = $urandom_range(0, 2) == 0;
      DMemReady     = $urandom_range(0, 3) != 0;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
